// File: rtl/spi_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_arb
//  Description : Shares one SPI bus among NUM_REQ requesters, each with its own
//                active-low select. Sends one MSB-first word and then
//                DUMMY_PULSES trailing sck pulses with ss held low.
//                Define SPI_ARB_FIXED_PRIO_EN for fixed priority (lowest index
//                wins). Without it, arbitration is round robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_arb #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_LENGTH  = 8,
    parameter int CLK_DIV      = 4,
    parameter int DUMMY_PULSES = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] tx_data,
    output logic [NUM_REQ-1:0]             gnt,
    output logic                           busy,
    output logic                           done,
    output logic [DATA_LENGTH-1:0]         rx_data,
    output logic                           sck,
    output logic                           mosi,
    input  logic                           miso,
    output logic [NUM_REQ-1:0]             ss_n
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(CLK_DIV);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DUMMY = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [PW-1:0] c_PH_LAST    = PW'(CLK_DIV - 1);
    localparam logic [3:0]    c_BIT_LAST   = 4'(DATA_LENGTH - 1);
    localparam logic [3:0]    c_DUMMY_LAST = 4'(DUMMY_PULSES - 1);

    logic [1:0]             r_state;
    logic [DATA_LENGTH-1:0] r_shreg;
    logic [3:0]             r_bitcnt;
    logic [3:0]             r_dcnt;
    logic [PW-1:0]          r_phase;
`ifndef SPI_ARB_FIXED_PRIO_EN
    logic [IW-1:0]          r_ptr;
`endif

    logic                   w_found;
    logic [IW-1:0]          w_win;
    logic [IW-1:0]          w_cand;
    logic [NUM_REQ-1:0]     w_onehot;
    logic [DATA_LENGTH-1:0] w_slot;
    logic [DATA_LENGTH-1:0] w_shift_nxt;
    logic [PW-1:0]          w_ph_nxt;

    // Winner search: starts at the pointer (or at 0 in fixed-priority mode) and wraps.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef SPI_ARB_FIXED_PRIO_EN
            w_cand = IW'(i);
`else
            w_cand = IW'((int'(r_ptr) + i) % NUM_REQ);
`endif
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_onehot    = NUM_REQ'(1) << w_win;
    assign w_slot      = tx_data[w_win*DATA_LENGTH +: DATA_LENGTH];
    assign w_shift_nxt = {r_shreg[DATA_LENGTH-2:0], miso};
    assign w_ph_nxt    = r_phase + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_shreg  <= '0;
            r_bitcnt <= '0;
            r_dcnt   <= '0;
            r_phase  <= '0;
`ifndef SPI_ARB_FIXED_PRIO_EN
            r_ptr    <= '0;
`endif
            gnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_data  <= '0;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= '1;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        gnt      <= w_onehot;
                        ss_n     <= ~w_onehot;
                        busy     <= 1'b1;
                        r_shreg  <= w_slot;
                        mosi     <= w_slot[DATA_LENGTH-1];
                        r_bitcnt <= c_BIT_LAST;
                        r_phase  <= '0;
                        sck      <= 1'b0;
                        r_state  <= c_SHIFT;
`ifndef SPI_ARB_FIXED_PRIO_EN
                        r_ptr    <= (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
`endif
                    end
                end
                c_SHIFT: begin
                    if (r_phase == c_PH_LAST) begin
                        // Edge ending the sck-high cycle: capture miso, advance bit.
                        r_phase <= '0;
                        sck     <= 1'b0;
                        r_shreg <= w_shift_nxt;
                        if (r_bitcnt == '0) begin
                            mosi   <= 1'b0;
                            r_dcnt <= '0;
                            if (DUMMY_PULSES == 0) begin
                                r_state <= c_DONE;
                                done    <= 1'b1;
                                rx_data <= w_shift_nxt;
                                ss_n    <= '1;
                            end else begin
                                r_state <= c_DUMMY;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt - 1'b1;
                            mosi     <= r_shreg[DATA_LENGTH-2];
                        end
                    end else begin
                        r_phase <= w_ph_nxt;
                        sck     <= (w_ph_nxt == c_PH_LAST);
                    end
                end
                c_DUMMY: begin
                    if (r_phase == c_PH_LAST) begin
                        r_phase <= '0;
                        sck     <= 1'b0;
                        if (r_dcnt == c_DUMMY_LAST) begin
                            r_state <= c_DONE;
                            done    <= 1'b1;
                            rx_data <= r_shreg;
                            ss_n    <= '1;
                        end else begin
                            r_dcnt <= r_dcnt + 1'b1;
                        end
                    end else begin
                        r_phase <= w_ph_nxt;
                        sck     <= (w_ph_nxt == c_PH_LAST);
                    end
                end
                c_DONE: begin
                    done    <= 1'b0;
                    gnt     <= '0;
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_arb
//  Description : Directed bench for spi_master_arb (default build, plus a
//                CLK_DIV=2 / DUMMY_PULSES=0 instance). Honours SPI_ARB_FIXED_PRIO_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  req;
    logic [31:0] tx_data;
    logic [3:0]  gnt;
    logic        busy, done, sck, mosi, miso;
    logic [7:0]  rx_data;
    logic [3:0]  ss_n;
    logic        miso_r;
    bit          v_loop;

    assign miso = v_loop ? mosi : miso_r;

    spi_master_arb #(.NUM_REQ(4), .DATA_LENGTH(8), .CLK_DIV(4), .DUMMY_PULSES(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .tx_data(tx_data), .gnt(gnt), .busy(busy),
        .done(done), .rx_data(rx_data), .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    logic [1:0]  req2;
    logic [15:0] tx2;
    logic [1:0]  gnt2, ss2_n;
    logic        busy2, done2, sck2, mosi2;
    logic [7:0]  rx2;

    spi_master_arb #(.NUM_REQ(2), .DATA_LENGTH(8), .CLK_DIV(2), .DUMMY_PULSES(0)) u_dut2 (
        .clk(clk), .rst(rst), .req(req2), .tx_data(tx2), .gnt(gnt2), .busy(busy2),
        .done(done2), .rx_data(rx2), .sck(sck2), .mosi(mosi2), .miso(mosi2), .ss_n(ss2_n)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0] req;
        logic [7:0] tx;
        bit         loop;
        logic [7:0] mw;
        int         win;
        logic [7:0] rx;
        bit         drop;
    } vec_t;

    vec_t vecs[8];

    // One full transfer on u_dut; req is driven just after a negedge, so the
    // grant edge is edge 1 and done is expected after edge 1 + 12*4 = 49.
    task automatic xfer(input vec_t v, input string nm);
        logic [3:0]  oh;
        logic [31:0] txw;
        logic [11:0] bits;
        int n, pulses, k, err;
        bit prev;
        oh = 4'(1) << v.win;
        txw = {4{~v.tx}};
        txw[v.win*8 +: 8] = v.tx;
        v_loop = v.loop;
        k = 0;
        miso_r = v.mw[7];
        req = v.req;
        tx_data = txw;
        n = 0; pulses = 0; err = 0; prev = 1'b0; bits = '0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (v.drop && n == 2) req = 4'b0;
            if (sck) begin
                if (!prev) begin
                    pulses++;
                    bits = {bits[10:0], mosi};
                end
                prev = 1'b1;
            end else begin
                if (prev) begin
                    k++;
                    miso_r = (k < 8) ? v.mw[7-k] : 1'b0;
                end
                prev = 1'b0;
            end
            if (busy && !done && (ss_n !== ~oh || gnt !== oh)) err++;
            if (done) break;
        end
        chk({nm, "_latency"}, n, 49);
        chk({nm, "_gnt"}, {28'b0, gnt}, {28'b0, oh});
        chk({nm, "_select"}, err, 0);
        chk({nm, "_mosi"}, {20'b0, bits}, {20'b0, v.tx, 4'b0});
        chk({nm, "_pulses"}, pulses, 12);
        chk({nm, "_rx"}, {24'b0, rx_data}, {24'b0, v.rx});
        req = 4'b0;
        @(negedge clk);
        chk({nm, "_idle"}, {22'b0, gnt, busy, done, ss_n}, {22'b0, 4'b0, 1'b0, 1'b0, 4'hF});
    endtask

    int rr_exp[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n, t, hi, win, dn, pulses, err;
        logic [7:0] bits;

        vecs[0] = '{4'b0001, 8'hA5, 1'b1, 8'h00, 0, 8'hA5, 1'b0};
        vecs[1] = '{4'b0010, 8'h3C, 1'b0, 8'h5A, 1, 8'h5A, 1'b0};
        vecs[2] = '{4'b1000, 8'hFF, 1'b0, 8'h00, 3, 8'h00, 1'b0};
        vecs[3] = '{4'b0100, 8'h01, 1'b0, 8'h80, 2, 8'h80, 1'b0};
        vecs[4] = '{4'b0110, 8'h96, 1'b1, 8'h00, 1, 8'h96, 1'b0};
`ifdef SPI_ARB_FIXED_PRIO_EN
        vecs[5] = '{4'b0101, 8'h4E, 1'b0, 8'hC3, 0, 8'hC3, 1'b0};
        vecs[7] = '{4'b1001, 8'h11, 1'b1, 8'h00, 0, 8'h11, 1'b0};
        rr_exp  = '{0, 0, 0, 0, 0};
`else
        vecs[5] = '{4'b0101, 8'h4E, 1'b0, 8'hC3, 2, 8'hC3, 1'b0};
        vecs[7] = '{4'b1001, 8'h11, 1'b1, 8'h00, 3, 8'h11, 1'b0};
        rr_exp  = '{0, 1, 2, 3, 0};
`endif
        vecs[6] = '{4'b0100, 8'h7E, 1'b1, 8'h00, 2, 8'h7E, 1'b1};

        req = '0; tx_data = '0; miso_r = 1'b0; v_loop = 1'b0;
        req2 = '0; tx2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {26'b0, gnt, busy, done}, 32'h0);
        chk("reset_bus", {26'b0, sck, mosi, ss_n}, {26'b0, 2'b00, 4'hF});
        chk("reset_rx", {24'b0, rx_data}, 32'h0);
        chk("reset_dut2", {18'b0, gnt2, busy2, done2, sck2, mosi2, ss2_n, rx2},
            {18'b0, 2'b00, 4'b0000, 2'b11, 8'h00});
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) xfer(vecs[i], $sformatf("vec%0d", i));

        // Fast divider, no dummy pulses: sck high on every second clock.
        req2 = 2'b01; tx2 = {8'h00, 8'hC3};
        n = 0; err = 0; bits = '0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (!done2 && sck2 !== (n % 2 == 0)) err++;
            if (sck2) bits = {bits[6:0], mosi2};
            if (done2) break;
        end
        chk("div2_latency", n, 17);
        chk("div2_sck", err, 0);
        chk("div2_mosi", {24'b0, bits}, 32'hC3);
        chk("div2_rx", {24'b0, rx2}, 32'hC3);
        req2 = '0;
        @(negedge clk);

        // All four requesting continuously.
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        v_loop = 1'b1; tx_data = {4{8'h5A}}; req = 4'hF;
        hi = 0;
        for (int g = 0; g < 5; g++) begin
            t = 0;
            while (t < 20) begin
                @(negedge clk);
                t++;
                if (gnt != 4'b0) break;
                if (ss_n == 4'hF) hi++;
            end
            win = -1;
            for (int j = 0; j < 4; j++) if (gnt[j]) win = j;
            chk($sformatf("arb_win%0d", g), win, rr_exp[g]);
            if (g > 0) chk($sformatf("arb_gap%0d", g), hi, 2);
            t = 0;
            while (!done && t < 100) begin
                @(negedge clk);
                t++;
            end
            chk($sformatf("arb_done%0d", g), {31'b0, done}, 32'h1);
            hi = (ss_n == 4'hF) ? 1 : 0;
        end
        req = 4'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of bit 3.
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        v_loop = 1'b1; tx_data = {4{8'hC9}}; req = 4'b0100;
        pulses = 0; t = 0;
        while (t < 100 && !(pulses == 4 && !sck)) begin
            @(negedge clk);
            t++;
            if (sck) pulses++;
        end
        chk("abort_busy_before", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_state", {22'b0, gnt, busy, done, sck, mosi, ss_n},
            {22'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF});
        chk("abort_rx", {24'b0, rx_data}, 32'h0);
        rst = 1'b0; req = 4'b0; dn = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("abort_no_done", dn, 0);
        xfer('{4'b0100, 8'hB4, 1'b1, 8'h00, 2, 8'hB4, 1'b0}, "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
